// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter family: index width, pointer wrap
// and the largest channel count the arbiter is meant to be built for.
package rr_arb_pkg;

  localparam int MAX_DEPTH = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Explicit wrap keeps non-power-of-2 channel counts from reaching illegal indices.
  function automatic int next_ptr(input int g, input int depth);
    return (g == depth - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin grant: requests at or above ptr win first, then the
// search wraps to the low channels; lowest set bit of a doubled vector gives both.
module rr_arb_core
  import rr_arb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [DEPTH-1:0]     gnt_onehot,
  output logic [SEL_WIDTH-1:0] gnt_idx
);

  logic [DEPTH-1:0]   hi_mask;
  logic [2*DEPTH-1:0] dbl_req;
  logic               found;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign hi_mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign dbl_req = {req, req & hi_mask};

  always_comb begin
    found      = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (!found && dbl_req[i]) begin
        found                   = 1'b1;
        gnt_onehot[i % DEPTH]   = 1'b1;
        gnt_idx                 = SEL_WIDTH'(i % DEPTH);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered round-robin N:1 stream mux with per-channel valid/ready.
// Define RR_ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DEPTH-1:0]           in_valid,
  input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  input  logic [DEPTH-1:0]           in_last,
  output logic                       out_last,
`endif
  output logic [DEPTH-1:0]           in_ready,
  output logic                       out_valid,
  output logic [BIT_WIDTH-1:0]       out_data,
  output logic [SEL_WIDTH-1:0]       out_sel,
  input  logic                       out_ready
);

  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [DEPTH-1:0]     arb_onehot;
  logic [SEL_WIDTH-1:0] arb_idx;
  logic                 gnt_valid;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic [SEL_WIDTH-1:0] ptr_next;
  logic                 load;
  logic                 xfer;
  logic [BIT_WIDTH-1:0] data_arr [DEPTH];

  assign load = !out_valid || out_ready;

  rr_arb_core #(
    .DEPTH     (DEPTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_core (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic                 lock_active;
  logic [SEL_WIDTH-1:0] lock_ch;

  // While locked only the owning channel can transfer, even if it goes idle.
  assign gnt_valid = lock_active ? in_valid[lock_ch] : |arb_onehot;
  assign gnt_idx   = lock_active ? lock_ch : arb_idx;
`else
  assign gnt_valid = |arb_onehot;
  assign gnt_idx   = arb_idx;
`endif

  assign xfer     = load && gnt_valid;
  assign ptr_next = SEL_WIDTH'(next_ptr(int'(gnt_idx), DEPTH));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chan
      assign data_arr[gi] = dataIn[BIT_WIDTH*gi +: BIT_WIDTH];
      assign in_ready[gi] = xfer && (gnt_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel     <= '0;
      rr_ptr      <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      out_last    <= 1'b0;
      lock_active <= 1'b0;
      lock_ch     <= '0;
`endif
    end else if (load) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= data_arr[gnt_idx];
        out_sel  <= gnt_idx;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        out_last <= in_last[gnt_idx];
        if (in_last[gnt_idx]) begin
          lock_active <= 1'b0;
          rr_ptr      <= ptr_next;
        end else begin
          lock_active <= 1'b1;
          lock_ch     <= gnt_idx;
        end
`else
        rr_ptr   <= ptr_next;
`endif
      end
    end
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, round-robin arbitrated N:1 mux with per-input valid/ready handshake.
- Successor to the plain combinational select mux: the select is generated internally by a fair arbiter, not supplied by the caller.
- One output register stage with throughput of 1 beat/cycle.
- Sits between multiple producer streams (DMA channels, requesters) and one shared consumer.

Parameters:
- BIT_WIDTH, 8, width of each input/output data word.
- DEPTH, 8, number of input channels; legal range 2..64, need not be a power of 2.
- SEL_WIDTH, log2(DEPTH) (ceiling), width of the granted-channel index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  DEPTH  per-channel valid; bit i belongs to channel i.
- dataIn  in  BIT_WIDTH*DEPTH  packed inputs; channel i occupies bits [BIT_WIDTH*i+BIT_WIDTH-1 : BIT_WIDTH*i].
- in_ready  out  DEPTH  per-channel ready; at most one bit set per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  BIT_WIDTH  registered data.
- out_sel  out  SEL_WIDTH  channel index the registered beat came from.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchroniser):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is combinational and therefore 0 while out_valid=0 only if no in_valid is set.
- load = !out_valid || out_ready. The output register accepts a new beat whenever it is empty or draining this cycle.
- Arbitration (combinational):
  - grant = first channel with in_valid set, searching rr_ptr, rr_ptr+1, … DEPTH-1, 0, … rr_ptr-1.
  - No in_valid set -> no grant.
- in_ready[i] = load && grant==i. in_ready must not depend on in_valid[i] except through the grant.
- Transfer on channel g when in_valid[g] && in_ready[g]:
  - Next edge: out_data<=dataIn slice g, out_sel<=g, out_valid<=1.
  - rr_ptr <= (g==DEPTH-1) ? 0 : g+1. Wrap is explicit, so non-power-of-2 DEPTH is correct.
- No transfer and out_ready=1: out_valid<=0; out_data and out_sel hold their values.
- out_valid=1 and out_ready=0: output frozen, all in_ready=0, rr_ptr unchanged.
- Latency: input transfer to out_valid is 1 cycle. Back-to-back streaming is 1 beat/cycle with no bubbles.
- Fairness: with all channels continuously valid, each channel is granted exactly once per DEPTH transfers.
- Producers may drop in_valid before being granted. A withdrawn request is simply skipped and rr_ptr is unchanged.
- Reset asserted mid-stream: the in-flight output beat is discarded and rr_ptr returns to 0.

Optional Feature:
- Macro RR_ARB_MUX_PKT_LOCK_EN.
- Defined:
  - Adds input port in_last (DEPTH bits) and output port out_last (1 bit, registered with the data, reset 0).
  - After a transfer from channel g with in_last[g]=0, the arbiter locks to g. Other channels get no grant even if g drops in_valid.
  - The lock releases after the transfer with in_last[g]=1; rr_ptr advances only on that release.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently, as described above.

Decomposition:
- Shared package rr_arb_pkg:
  - log2 ceiling function.
  - Constant function for the next pointer with wrap.
  - Localparam for the maximum DEPTH (64).
- One sub-module rr_arb_core: parameter DEPTH; inputs req[DEPTH] and ptr; outputs gnt_onehot and gnt_idx.
  - Pure combinational double-width mask-and-priority-encode.
  - Reusable by other arbiters.
- Top level holds rr_ptr, the output register, the lock state, and the data mux.

Test Plan:
- Reset, then in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 for 5 cycles.
- DEPTH=8, all in_valid=1, dataIn slice i=0xA0+i, out_ready=1 -> out_sel sequence 0,1,…,7,0 on consecutive cycles; out_data 0xA0..0xA7; no bubbles.
- in_valid=8'b1000_0100 with rr_ptr=3 -> grant 7 first, then 2. Next, with only channel 2 valid -> grant 2 again.
- Accept one beat, then hold out_ready=0 for 4 cycles -> out_data and out_sel stable, in_ready=0. Release -> next grant follows the pointer.
- DEPTH=5, all valid -> sel 0..4 then 0: wrap is correct with no grant of an illegal index 5–7.
- RR_ARB_MUX_PKT_LOCK_EN, channel 1 sends a 3-beat packet (in_last on beat 3) while channel 0 is valid -> sel 1,1,1 then 0; out_last=1 only on the third beat.
